cluster_count_pipe: RTL and testbench

- Parametrised, pipelined population counter for the cluster-finder VPF (valid pattern flag) vector. Supports any SIZE, not only 768 or 1536.
- Adds a runtime overflow threshold, an overflow stretcher, a peak-count tracker and a saturating overflow-event counter.
- Sits beside the cluster finder. Its outputs feed the overflow/truncation logic and monitoring registers.

---
 rtl/cluster_count_pkg.sv | 27 ++
 rtl/cluster_count_adder_level.sv | 36 +++
 rtl/cluster_count_pipe.sv | 125 ++++++++++++
 tb/tb_cluster_count_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_count_pkg.sv
// cluster_count_pkg: shared helpers for the VPF population-count pipeline.
package cluster_count_pkg;

    localparam int MAX_GROUP = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic logic [3:0] count1s(input logic [MAX_GROUP-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < MAX_GROUP; i++)
            c = c + 4'(v[i]);
        return c;
    endfunction

    // Cycles from sampling vpfs_i to the edge after which cnt_o shows it, plus one.
    function automatic int lat_calc(input int size, input int group);
        return 3 + clog2((size + group - 1) / group);
    endfunction

endpackage

// File: rtl/cluster_count_adder_level.sv
// cluster_count_adder_level: one registered pairwise-sum level of the popcount tree.
module cluster_count_adder_level
    import cluster_count_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int W_IN  = 4,
    parameter int W_OUT = W_IN + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N_IN*W_IN-1:0]          i_data,
    output logic [((N_IN+1)/2)*W_OUT-1:0] o_data
);
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*W_OUT-1:0] w_sum;
    logic [N_OUT*W_OUT-1:0] r_sum;

    // An odd leftover element rides through the level unchanged.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_IN / 2; i++)
            w_sum[i*W_OUT +: W_OUT] = W_OUT'(i_data[2*i*W_IN +: W_IN])
                                    + W_OUT'(i_data[(2*i+1)*W_IN +: W_IN]);
        if (N_IN % 2 == 1)
            w_sum[(N_OUT-1)*W_OUT +: W_OUT] = W_OUT'(i_data[(N_IN-1)*W_IN +: W_IN]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_sum <= '0;
        else          r_sum <= w_sum;
    end

    assign o_data = r_sum;

endmodule

// File: rtl/cluster_count_pipe.sv
// cluster_count_pipe: pipelined VPF popcount with overflow flag, stretcher,
// peak tracker and saturating overflow-event counter.
module cluster_count_pipe
    import cluster_count_pkg::*;
#(
    parameter int SIZE  = 1536,
    parameter int GROUP = 6,
    parameter int HOLD  = 4,
    parameter int EVT_W = 16,
    parameter int CNT_W = clog2(SIZE + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SIZE-1:0]  vpfs_i,
    input  logic             valid_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             peak_clr_i,
    input  logic             evt_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             valid_o,
    output logic             overflow_o,
    output logic             overflow_hold_o,
    output logic [CNT_W-1:0] peak_o,
    output logic [EVT_W-1:0] evt_cnt_o
);
    localparam int NG   = (SIZE + GROUP - 1) / GROUP;
    localparam int TREE = clog2(NG);
    localparam int GW   = clog2(GROUP + 1);
    localparam int W0   = GW < CNT_W ? GW : CNT_W;
    localparam int HW   = clog2(HOLD + 1);

    // Input copy kept private so it is never shared with cluster-finder registers.
    (* keep = "true", shreg_extract = "no" *) logic [SIZE-1:0] r_vpfs;
    logic [TREE+1:0]     r_vld;
    logic [NG*GROUP-1:0] w_pad;
    logic [NG*W0-1:0]    w_grp;
    logic [NG*W0-1:0]    r_grp;
    logic [CNT_W-1:0]    w_sum;
    logic                w_vld;
    logic                w_ovf;
    logic [HW-1:0]       r_hold;

    always_comb begin
        w_pad = '0;
        w_pad[SIZE-1:0] = r_vpfs;
    end

    always_comb begin
        w_grp = '0;
        for (int g = 0; g < NG; g++)
            w_grp[g*W0 +: W0] = W0'(count1s(MAX_GROUP'(w_pad[g*GROUP +: GROUP])));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vpfs <= '0;
            r_grp  <= '0;
            r_vld  <= '0;
        end else begin
            r_vpfs <= vpfs_i;
            r_grp  <= w_grp;
            r_vld  <= {r_vld[TREE:0], valid_i};
        end
    end

    // Each level grows one bit until the full count width is reached.
    for (genvar l = 0; l < TREE; l++) begin : g_lvl
        localparam int NI = (NG + (1 << l) - 1) >> l;
        localparam int WI = W0 + l < CNT_W ? W0 + l : CNT_W;
        localparam int WO = WI + 1 < CNT_W ? WI + 1 : CNT_W;
        logic [NI*WI-1:0]         w_in;
        logic [((NI+1)/2)*WO-1:0] w_out;
        if (l == 0) begin : g_first
            assign w_in = r_grp;
        end else begin : g_next
            assign w_in = g_lvl[l-1].w_out;
        end
        cluster_count_adder_level #(
            .N_IN (NI),
            .W_IN (WI),
            .W_OUT(WO)
        ) u_lvl (
            .clock  (clock),
            .reset_n(reset_n),
            .i_data (w_in),
            .o_data (w_out)
        );
    end

    if (TREE == 0) begin : g_flat
        assign w_sum = r_grp;
    end else begin : g_tree
        assign w_sum = g_lvl[TREE-1].w_out;
    end

    assign w_vld = r_vld[TREE+1];
    assign w_ovf = w_vld && (w_sum > thresh_i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_o           <= '0;
            valid_o         <= 1'b0;
            overflow_o      <= 1'b0;
            overflow_hold_o <= 1'b0;
            r_hold          <= '0;
            peak_o          <= '0;
            evt_cnt_o       <= '0;
        end else begin
            cnt_o           <= w_sum;
            valid_o         <= w_vld;
            overflow_o      <= w_ovf;
            overflow_hold_o <= w_ovf || (r_hold != '0);
            r_hold          <= w_ovf ? HW'(HOLD) : (r_hold != '0 ? r_hold - 1'b1 : r_hold);
            if (peak_clr_i)
                peak_o <= w_vld ? w_sum : '0;
            else if (w_vld && w_sum > peak_o)
                peak_o <= w_sum;
            if (evt_clr_i)
                evt_cnt_o <= EVT_W'(w_ovf);
            else if (w_ovf && evt_cnt_o != '1)
                evt_cnt_o <= evt_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_cluster_count_pipe.sv
// tb_cluster_count_pipe: table, directed and randomized checks of cluster_count_pipe
// against a countones/queue reference model.
module tb_cluster_count_pipe;
    localparam int SA = 1536, CA = 11, LA = 11, HA = 4, EA = 16;
    localparam int SB = 769,  CB = 10, LB = 11;
    localparam int SC = 64,   CC = 7,  LC = 7,  HC = 2, EC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [SA-1:0] a_vpfs = '0;
    logic          a_valid = 1'b0, a_pclr = 1'b0, a_eclr = 1'b0;
    logic [CA-1:0] a_thresh = CA'(1000);
    logic [CA-1:0] a_cnt, a_peak;
    logic          a_vo, a_ovf, a_hold;
    logic [EA-1:0] a_evt;

    logic [SB-1:0] b_vpfs = '0;
    logic          b_valid = 1'b0;
    logic [CB-1:0] b_thresh = '1;
    logic [CB-1:0] b_cnt, b_peak;
    logic          b_vo, b_ovf, b_hold;
    logic [15:0]   b_evt;

    logic [SC-1:0] c_vpfs = '0;
    logic          c_valid = 1'b0, c_eclr = 1'b0;
    logic [CC-1:0] c_thresh = CC'(10);
    logic [CC-1:0] c_cnt, c_peak;
    logic          c_vo, c_ovf, c_hold;
    logic [EC-1:0] c_evt;

    cluster_count_pipe #(.SIZE(SA), .GROUP(6), .HOLD(HA), .EVT_W(EA)) dut_a (
        .clock(clk), .reset_n(rst_n), .vpfs_i(a_vpfs), .valid_i(a_valid), .thresh_i(a_thresh),
        .peak_clr_i(a_pclr), .evt_clr_i(a_eclr), .cnt_o(a_cnt), .valid_o(a_vo),
        .overflow_o(a_ovf), .overflow_hold_o(a_hold), .peak_o(a_peak), .evt_cnt_o(a_evt));

    cluster_count_pipe #(.SIZE(SB), .GROUP(6), .HOLD(4), .EVT_W(16)) dut_b (
        .clock(clk), .reset_n(rst_n), .vpfs_i(b_vpfs), .valid_i(b_valid), .thresh_i(b_thresh),
        .peak_clr_i(1'b0), .evt_clr_i(1'b0), .cnt_o(b_cnt), .valid_o(b_vo),
        .overflow_o(b_ovf), .overflow_hold_o(b_hold), .peak_o(b_peak), .evt_cnt_o(b_evt));

    cluster_count_pipe #(.SIZE(SC), .GROUP(4), .HOLD(HC), .EVT_W(EC)) dut_c (
        .clock(clk), .reset_n(rst_n), .vpfs_i(c_vpfs), .valid_i(c_valid), .thresh_i(c_thresh),
        .peak_clr_i(1'b0), .evt_clr_i(c_eclr), .cnt_o(c_cnt), .valid_o(c_vo),
        .overflow_o(c_ovf), .overflow_hold_o(c_hold), .peak_o(c_peak), .evt_cnt_o(c_evt));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [SA-1:0] ones_a(input int n);
        logic [SA-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Reference model for dut_a: a LAT-deep queue of {popcount, valid} per sampled vector.
    typedef struct { int cnt; bit v; } rec_t;
    rec_t q[$];
    rec_t s;
    int   e_cnt, e_peak, e_evt, since;
    bit   e_v, e_ovf, e_hold;
    logic chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < LA; i++) q.push_back('{0, 1'b0});
            e_cnt = 0; e_v = 0; e_ovf = 0; e_hold = 0; e_peak = 0; e_evt = 0;
            since = HA + 1;
        end else begin
            q.push_back('{$countones(a_vpfs), a_valid});
            q.delete(0);
            s = q[0];
            e_cnt = s.cnt;
            e_v = s.v;
            e_ovf = s.v && (s.cnt > int'(a_thresh));
            since = e_ovf ? 0 : (since > HA ? since : since + 1);
            e_hold = since <= HA;
            if (a_pclr) e_peak = s.v ? s.cnt : 0;
            else if (s.v && s.cnt > e_peak) e_peak = s.cnt;
            if (a_eclr) e_evt = e_ovf ? 1 : 0;
            else if (e_ovf && e_evt < (1 << EA) - 1) e_evt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_cnt", a_cnt, e_cnt);
            chk("model_valid", a_vo, e_v);
            chk("model_ovf", a_ovf, e_ovf);
            chk("model_hold", a_hold, e_hold);
            chk("model_peak", a_peak, e_peak);
            chk("model_evt", a_evt, e_evt);
        end
    end

    typedef struct { int nset; bit v; int thr; int cnt; bit ovf; } vec_t;
    vec_t tbl[9];
    int   b2b[4];
    int   md;
    logic [31:0] x;

    initial begin
        tbl[0] = '{0,    1, 1000, 0,    0};
        tbl[1] = '{1,    1, 0,    1,    1};
        tbl[2] = '{1000, 1, 1000, 1000, 0};
        tbl[3] = '{1001, 1, 1000, 1001, 1};
        tbl[4] = '{1536, 1, 2047, 1536, 0};
        tbl[5] = '{1536, 0, 0,    1536, 0};
        tbl[6] = '{37,   1, 36,   37,   1};
        tbl[7] = '{5,    0, 1,    5,    0};
        tbl[8] = '{1535, 1, 1535, 1535, 0};
        b2b = '{0, 6, 767, 1536};

        repeat (3) tick();
        chk("rst_cnt", a_cnt, 0);
        chk("rst_valid", a_vo, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_hold", a_hold, 0);
        chk("rst_peak", a_peak, 0);
        chk("rst_evt", a_evt, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        tick(); a_vpfs = ones_a(1); a_valid = 1'b1;
        for (int j = 1; j <= LA + 3; j++) begin
            tick(); a_vpfs = '0; a_valid = 1'b0;
            chk("single_cnt", a_cnt, j == LA ? 1 : 0);
            chk("single_valid", a_vo, j == LA ? 1 : 0);
        end

        tick(); a_vpfs = '1; a_valid = 1'b1;
        for (int j = 1; j <= LA + 6; j++) begin
            tick(); a_vpfs = '0; a_valid = 1'b0;
            if (j == LA) begin
                chk("full_cnt", a_cnt, SA);
                chk("full_ovf", a_ovf, 1);
                chk("full_evt", a_evt, 1);
            end
            if (j >= LA) chk("full_hold", a_hold, j <= LA + HA ? 1 : 0);
        end

        for (int j = 0; j <= LA + 3; j++) begin
            tick();
            if (j < 4) begin a_vpfs = ones_a(b2b[j]); a_valid = 1'b1; end
            else begin a_vpfs = '0; a_valid = 1'b0; end
            if (j >= LA) chk("b2b_cnt", a_cnt, b2b[j-LA]);
        end
        chk("b2b_peak", a_peak, SA);

        for (int j = 0; j <= LA; j++) begin
            tick();
            a_vpfs = j == 0 ? ones_a(6) : '0;
            a_valid = j == 0;
            a_pclr = j == LA - 1;
        end
        chk("pclr_peak", a_peak, 6);
        a_pclr = 1'b0;

        foreach (tbl[k]) begin
            a_thresh = CA'(tbl[k].thr);
            for (int j = 0; j <= LA; j++) begin
                tick();
                a_vpfs = j == 0 ? ones_a(tbl[k].nset) : '0;
                a_valid = j == 0 && tbl[k].v;
                if (j == LA) begin
                    chk("tbl_cnt", a_cnt, tbl[k].cnt);
                    chk("tbl_ovf", a_ovf, tbl[k].ovf);
                end
            end
        end
        a_thresh = CA'(1000);

        for (int r = 0; r < 400; r++) begin
            tick();
            md = $urandom_range(0, 4);
            for (int w = 0; w < SA / 32; w++) begin
                x = $urandom;
                if (md == 0) x = x & $urandom & $urandom;
                if (md == 1) x = x | $urandom | $urandom;
                if (md == 3) x = '1;
                if (md == 4) x = '0;
                a_vpfs[w*32 +: 32] = x;
            end
            a_valid = $urandom_range(0, 3) != 0;
            a_pclr = $urandom_range(0, 30) == 0;
            a_eclr = $urandom_range(0, 30) == 0;
            if ($urandom_range(0, 20) == 0) a_thresh = CA'($urandom_range(600, 1100));
        end
        a_pclr = 1'b0; a_eclr = 1'b0; a_thresh = CA'(1000);

        for (int j = 0; j < LA + 3; j++) begin
            tick(); a_vpfs = '1; a_valid = 1'b1;
        end
        chk("pre_rst_cnt", a_cnt, SA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", a_cnt, 0);
        chk("arst_valid", a_vo, 0);
        chk("arst_ovf", a_ovf, 0);
        chk("arst_hold", a_hold, 0);
        chk("arst_peak", a_peak, 0);
        chk("arst_evt", a_evt, 0);
        tick(); tick();
        rst_n = 1'b1; a_vpfs = '0; a_valid = 1'b0;
        for (int j = 0; j <= LA + 4; j++) begin
            tick();
            a_vpfs = j == 2 ? ones_a(3) : '0;
            a_valid = j == 2;
            chk("post_rst_cnt", a_cnt, j == LA + 2 ? 3 : 0);
        end

        tick(); b_vpfs = '0; b_vpfs[SB-1] = 1'b1; b_vpfs[4:0] = '1; b_valid = 1'b1;
        for (int j = 1; j <= LB + 1; j++) begin
            tick(); b_vpfs = '0; b_valid = 1'b0;
            if (j == LB - 1) chk("pad_early", b_cnt, 0);
            if (j == LB) begin
                chk("pad_cnt", b_cnt, 6);
                chk("pad_valid", b_vo, 1);
            end
        end
        tick(); b_vpfs = '1; b_valid = 1'b1;
        for (int j = 1; j <= LB; j++) begin
            tick(); b_vpfs = '0; b_valid = 1'b0;
            if (j == LB) chk("pad_full", b_cnt, SB);
        end

        for (int j = 0; j <= 40; j++) begin
            tick();
            c_vpfs = {SC{j < 30}};
            c_valid = j < 30;
            c_eclr = j == LC + 24;
            if (j == LC + 13) chk("sat_evt14", c_evt, 14);
            if (j == LC + 19) chk("sat_evt15", c_evt, 15);
            if (j == LC + 23) chk("sat_stay15", c_evt, 15);
            if (j == LC + 25) chk("eclr_evt", c_evt, 1);
            if (j == LC + 26) chk("eclr_next", c_evt, 2);
            if (j >= 29 + LC) chk("c_hold", c_hold, j <= 29 + LC + HC ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
